// File: rtl/mc_ctrl_if.sv
// Extension-unit handshake bundle: mc_ctrl_fsm drives the master side,
// the extension units (FPU, multiplier, ...) sit on the slave side.
interface mc_ctrl_if #(
    parameter int unsigned XU_COUNT = 2
);
    logic [XU_COUNT-1:0] xu_start;
    logic [2:0]          xu_sel;
    logic [XU_COUNT-1:0] xu_done;
    logic [3:0]          xu_flags;

    modport master (output xu_start, output xu_sel, input xu_done, input xu_flags);
    modport slave  (input xu_start, input xu_sel, output xu_done, output xu_flags);
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit: instruction decode, NZCV flags/condition check and
// extension-unit handshake. Define MC_CTRL_XU_TIMEOUT_EN to enable the XUWAIT abort.
module mc_ctrl_fsm #(
    parameter int unsigned XU_COUNT   = 2,
    parameter int unsigned XU_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    mc_ctrl_if.master   xu,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic [3:0]  Flags,
    output logic        undef_instr,
    output logic        xu_timeout
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB,
        MEMWR, BRANCH, XUSTART, XUWAIT, XUWB
    } state_t;

    state_t state, state_next;
    logic [3:0] flags_q;
    logic       flags_from_alu, flags_from_xu;
    logic       cond_ok, idx_ok, done_sel, cnt_expired;

    logic [3:0] cond;
    logic [1:0] op;
    logic [3:0] cmd;
    logic [2:0] idx;
    logic       i_bit, s_bit, u_bit;
    logic [XU_COUNT-1:0] idx_onehot;
    logic       unused_instr;

    assign cond         = Instr[31:28];
    assign op           = Instr[27:26];
    assign i_bit        = Instr[25];
    assign cmd          = Instr[24:21];
    assign u_bit        = Instr[23];
    assign idx          = Instr[23:21];
    assign s_bit        = Instr[20];
    assign unused_instr = ^Instr[19:0];

    assign idx_onehot = XU_COUNT'(1) << idx;
    assign idx_ok     = {29'd0, idx} < XU_COUNT;
    assign done_sel   = |(xu.xu_done & idx_onehot);

    // Flags are NZCV: [3]=N [2]=Z [1]=C [0]=V
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flags_q[2];
            4'b0001: cond_ok = !flags_q[2];
            4'b0010: cond_ok = flags_q[1];
            4'b0011: cond_ok = !flags_q[1];
            4'b0100: cond_ok = flags_q[3];
            4'b0101: cond_ok = !flags_q[3];
            4'b0110: cond_ok = flags_q[0];
            4'b0111: cond_ok = !flags_q[0];
            4'b1000: cond_ok = flags_q[1] && !flags_q[2];
            4'b1001: cond_ok = !flags_q[1] || flags_q[2];
            4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

`ifdef MC_CTRL_XU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(XU_TIMEOUT + 1);
    logic [CNT_W-1:0] xu_cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            xu_cnt <= '0;
        else if (state == XUSTART)
            xu_cnt <= '0;
        else if (state == XUWAIT && !done_sel)
            xu_cnt <= xu_cnt + CNT_W'(1);
    end

    assign cnt_expired = (xu_cnt == CNT_W'(XU_TIMEOUT));
`else
    logic unused_timeout;
    assign unused_timeout = (XU_TIMEOUT == 0);
    assign cnt_expired    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FETCH;
            flags_q <= '0;
        end else begin
            state <= state_next;
            if (flags_from_alu)
                flags_q <= ALUFlags;
            else if (flags_from_xu)
                flags_q <= xu.xu_flags;
        end
    end

    always_comb begin
        state_next     = state;
        PCWrite        = 1'b0;
        MemWrite       = 1'b0;
        RegWrite       = 1'b0;
        IRWrite        = 1'b0;
        AdrSrc         = 1'b0;
        ALUSrcA        = 2'b00;
        ALUSrcB        = 2'b00;
        ResultSrc      = 2'b00;
        ALUControl     = 4'b0100;
        ImmSrc         = op;
        Flags          = flags_q;
        undef_instr    = 1'b0;
        xu_timeout     = 1'b0;
        xu.xu_start    = '0;
        xu.xu_sel      = idx;
        flags_from_alu = 1'b0;
        flags_from_xu  = 1'b0;

        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                if (!cond_ok)
                    state_next = FETCH;
                else begin
                    case (op)
                        2'b00:   state_next = i_bit ? EXECI : EXECR;
                        2'b01:   state_next = MEMADR;
                        2'b10:   state_next = BRANCH;
                        default: begin
                            if (idx_ok)
                                state_next = XUSTART;
                            else begin
                                undef_instr = 1'b1;
                                state_next  = FETCH;
                            end
                        end
                    endcase
                end
            end
            EXECR, EXECI: begin
                ALUSrcB        = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl     = cmd;
                flags_from_alu = s_bit;
                // TST/TEQ/CMP/CMN only set flags
                state_next     = (cmd[3:2] == 2'b10) ? FETCH : ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = u_bit ? 4'b0100 : 4'b0010;
                state_next = s_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc     = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                ResultSrc  = 2'b01;
                state_next = FETCH;
            end
            MEMWR: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                state_next = FETCH;
            end
            XUSTART: begin
                xu.xu_start = idx_onehot;
                state_next  = XUWAIT;
            end
            XUWAIT: begin
                if (done_sel)
                    state_next = XUWB;
                else if (cnt_expired) begin
                    xu_timeout = 1'b1;
                    state_next = FETCH;
                end
            end
            XUWB: begin
                RegWrite      = 1'b1;
                ResultSrc     = 2'b11;
                flags_from_xu = s_bit;
                state_next    = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // Reset overrides every output and blocks any register update
        if (!reset) begin
            PCWrite        = 1'b0;
            MemWrite       = 1'b0;
            RegWrite       = 1'b0;
            IRWrite        = 1'b0;
            AdrSrc         = 1'b0;
            ALUSrcA        = 2'b00;
            ALUSrcB        = 2'b00;
            ResultSrc      = 2'b00;
            ALUControl     = 4'b0000;
            ImmSrc         = 2'b00;
            Flags          = 4'b0000;
            undef_instr    = 1'b0;
            xu_timeout     = 1'b0;
            xu.xu_start    = '0;
            xu.xu_sel      = 3'b000;
            flags_from_alu = 1'b0;
            flags_from_xu  = 1'b0;
            state_next     = FETCH;
        end
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control unit for the ARM-subset core. It merges instruction classification, condition evaluation with an architectural NZCV flag register, and the main multicycle state machine into a single block. It adds a start/done handshake to up to `XU_COUNT` variable-latency extension units (FPU, multiplier, …). It sits between the instruction register and the datapath muxes/enables, replacing the fixed-latency controller path.

## Interface
- `XU_COUNT`, default 2: number of extension units, 1..8.
- `XU_TIMEOUT`, default 255: maximum cycles spent in XUWAIT before abort. Counter width is `$clog2(XU_TIMEOUT+1)`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Instr`  in  32  current instruction register contents.
- `ALUFlags`  in  4  NZCV from the ALU, combinational, valid in the same cycle.
- `xu_done`  in  `XU_COUNT`  per-unit completion level.
- `xu_flags`  in  4  NZCV from the selected unit, valid while its done is high.
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite`, `AdrSrc`  out  1 each  datapath strobes and select.
- `ALUSrcA`  out  2  00 = RegA, 01 = PC.
- `ALUSrcB`  out  2  00 = RegB, 01 = ExtImm, 10 = const 4.
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = XU result.
- `ImmSrc`  out  2  equals `Instr[27:26]`.
- `ALUControl`  out  4  ALU command.
- `xu_start`  out  `XU_COUNT`  one-hot start pulse.
- `xu_sel`  out  3  selected unit index, equal to `Instr[23:21]`.
- `Flags`  out  4  architectural NZCV.
- `undef_instr`, `xu_timeout`  out  1 each  one-cycle event pulses.

## Operation
- Instruction class from `Op = Instr[27:26]`:
  - 00: data-processing. I = `Instr[25]`, cmd = `Instr[24:21]`, S = `Instr[20]`.
  - 01: memory. L = `Instr[20]`, U = `Instr[23]`.
  - 10: branch.
  - 11: extension unit (XU). Unit index = `Instr[23:21]`, S = `Instr[20]`.
- Condition `Instr[31:28]` uses the standard ARM encodings 0000..1110 evaluated against `Flags`. 1111 is treated as never.
- States: FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, XUSTART, XUWAIT, XUWB.
- FETCH:
  - Outputs: `IRWrite`=1, `PCWrite`=1, `AdrSrc`=0, `ALUSrcA`=01, `ALUSrcB`=10, `ALUControl`=0100 (ADD), `ResultSrc`=10.
  - Next state: DECODE.
- DECODE:
  - Outputs: `ALUSrcA`=01, `ALUSrcB`=10, ADD.
  - Condition false: go to FETCH; nothing is written.
  - Otherwise: Op 00 goes to EXECI if I=1, else EXECR. Op 01 goes to MEMADR. Op 10 goes to BRANCH. Op 11 goes to XUSTART if index < `XU_COUNT`.
  - Op 11 with index >= `XU_COUNT`: pulse `undef_instr`, go to FETCH.
- EXECR / EXECI:
  - Outputs: `ALUSrcB` = 00 in EXECR, 01 in EXECI; `ALUControl` = cmd.
  - If S=1, `Flags` <= `ALUFlags` at the end of the cycle.
  - Next state: FETCH if cmd is 1000..1011 (TST/TEQ/CMP/CMN), else ALUWB.
- ALUWB: `RegWrite`=1, `ResultSrc`=00. Next state: FETCH.
- MEMADR:
  - Outputs: `ALUSrcB`=01; `ALUControl` = 0100 if U=1, else 0010.
  - Next state: MEMRD if L=1, else MEMWR.
- MEMRD: `AdrSrc`=1, then MEMWB. MEMWB: `RegWrite`=1, `ResultSrc`=01, then FETCH.
- MEMWR: `AdrSrc`=1, `MemWrite`=1, then FETCH.
- BRANCH: `ALUSrcA`=01, `ALUSrcB`=01, ADD, `ResultSrc`=10, `PCWrite`=1. Next state: FETCH.
- XUSTART:
  - `xu_start[idx]`=1 for exactly one cycle; the timeout counter clears.
  - Next state: XUWAIT.
- XUWAIT:
  - If `xu_done[idx]`=1, go to XUWB; done from any other unit is ignored.
  - Otherwise the counter increments.
- XUWB:
  - Outputs: `RegWrite`=1, `ResultSrc`=11.
  - If S=1, `Flags` <= `xu_flags`.
  - Next state: FETCH.
- Any output not listed for a state is 0. `ALUControl` defaults to 0100.

## Timing
- All control outputs are Moore outputs, decoded from the registered state. Exceptions: `undef_instr` (DECODE plus `Instr`) and `xu_timeout`.
- Minimum cycle counts per instruction:
  - Condition fail: 2.
  - Branch: 3.
  - Compare: 3.
  - Data-processing with writeback: 4.
  - Store: 4.
  - Load: 5.
  - XU: 5 + extra wait cycles. Done high on the first XUWAIT cycle gives 5 cycles total.
- `xu_done` already high in XUSTART is ignored; the unit must hold done until XUWB.
- `Flags` update and `RegWrite` take effect at the same clock edge that leaves the state.
- Reset:
  - While `reset`=0, every output is forced to 0 and `ALUControl` to 0000, regardless of state.
  - At the edge: state <= FETCH, `Flags` <= 0000, counter <= 0.
  - A reset arriving mid-XUWAIT aborts the operation; no `RegWrite` or `Flags` update follows.
- `undef_instr` and `xu_timeout` are never asserted together.

## Configuration
- `MC_CTRL_XU_TIMEOUT_EN` defined:
  - In XUWAIT, when the counter reaches `XU_TIMEOUT` with done still low, pulse `xu_timeout` for one cycle and go to FETCH.
  - No writeback and no flag update.
- Not defined: no counter is synthesised, XUWAIT waits indefinitely, and `xu_timeout` is tied to 0.

## Test plan
- Reset held low for 3 cycles with `Instr`=0xE0810002 → all outputs 0. After release: FETCH (`IRWrite`=1, `PCWrite`=1), DECODE, EXECR (`ALUControl`=0100), ALUWB (`RegWrite`=1), FETCH; `Flags` stays 0000.
- `Instr`=0xE3500000 (CMP #0) with `ALUFlags`=0100 → `Flags`=0100 after EXECI, no `RegWrite`. Then `Instr`=0x1A000003 (BNE) → DECODE returns to FETCH with no `PCWrite` outside FETCH.
- `Instr`=0xE5910004 (LDR) → exactly 5 cycles; `AdrSrc`=1 in MEMRD; `RegWrite`=1 with `ResultSrc`=01 in MEMWB. STR 0xE5810004 → `MemWrite`=1 in exactly one cycle.
- XU op, S=1, unit 1 (`Instr`=0xEC300000), `XU_COUNT`=2; `xu_done[1]` rises 7 cycles after `xu_start`=2'b10 → `RegWrite`/`ResultSrc`=11 in XUWB, `Flags`=`xu_flags`. An unrelated `xu_done[0]` pulse during the wait is ignored.
- Unit index 5 with `XU_COUNT`=2 → one `undef_instr` pulse in DECODE, no `xu_start`, back to FETCH.
- With `MC_CTRL_XU_TIMEOUT_EN`, `XU_TIMEOUT`=10, done never asserted → `xu_timeout` pulses exactly once, then FETCH, no `RegWrite`. A repeat run with reset asserted mid-wait returns to FETCH with no pulse.
